// File: rtl/hazard3_instr_aligner.sv
// Halfword prefetch queue and aligner between the fetch bus and the decompressor.
// Presents a 32-bit window starting at the oldest halfword and retires 1 or 2 halfwords per issue.
module hazard3_instr_aligner #(
    parameter int unsigned DEPTH_HW = 6,
    parameter int unsigned W_LEVEL  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [31:0]        fetch_data,
    input  logic               fetch_skip_lo,
    input  logic               fetch_err,
    output logic [31:0]        dec_instr,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic               dec_is_32bit,
    output logic               dec_err,
    output logic [W_LEVEL-1:0] level
);

    localparam logic [W_LEVEL-1:0] PushLimit = W_LEVEL'(DEPTH_HW - 2);

    logic [15:0]         hw_q   [DEPTH_HW];
    logic [15:0]         hw_d   [DEPTH_HW];
    logic [15:0]         hw_ext [DEPTH_HW+2];
    logic [DEPTH_HW-1:0] err_q, err_d;
    logic [DEPTH_HW+1:0] err_ext;
    logic [W_LEVEL-1:0]  level_q, level_d;
    logic [W_LEVEL-1:0]  n_ret, n_push, rem;
    logic                has_one, has_two, is32, push, consume;

    assign has_one = level_q != '0;
    assign has_two = level_q >= W_LEVEL'(2);
    assign is32    = has_one && (hw_q[0][1:0] == 2'b11);

    assign level        = level_q;
    assign dec_is_32bit = is32;
    assign dec_valid    = !flush && has_one && (!is32 || has_two);
    assign dec_err      = has_one && (err_q[0] || (is32 && err_q[1]));
    assign dec_instr    = has_two ? {hw_q[1], hw_q[0]} :
                          has_one ? {16'h0, hw_q[0]}   : 32'h0;

    // Depends on registered level only, so no dec_ready -> fetch_ready path.
    assign fetch_ready = !flush && (level_q <= PushLimit);

    assign push    = fetch_valid && fetch_ready;
    assign consume = dec_valid && dec_ready;
    assign n_ret   = !consume ? '0 : (is32 ? W_LEVEL'(2) : W_LEVEL'(1));
    assign n_push  = !push ? '0 : (fetch_skip_lo ? W_LEVEL'(1) : W_LEVEL'(2));
    assign rem     = level_q - n_ret;

    // Two zero pads let the shift read a fixed index without range checks.
    always_comb begin
        for (int i = 0; i < DEPTH_HW; i++) begin
            hw_ext[i] = hw_q[i];
        end
        hw_ext[DEPTH_HW]   = 16'h0;
        hw_ext[DEPTH_HW+1] = 16'h0;
        err_ext            = {2'b00, err_q};
    end

    always_comb begin
        level_d = rem + n_push;
        err_d   = '0;
        for (int i = 0; i < DEPTH_HW; i++) begin
            hw_d[i] = 16'h0;
            if (i < int'(rem)) begin
                case (n_ret)
                    W_LEVEL'(2): begin
                        hw_d[i]  = hw_ext[i+2];
                        err_d[i] = err_ext[i+2];
                    end
                    W_LEVEL'(1): begin
                        hw_d[i]  = hw_ext[i+1];
                        err_d[i] = err_ext[i+1];
                    end
                    default: begin
                        hw_d[i]  = hw_ext[i];
                        err_d[i] = err_ext[i];
                    end
                endcase
            end
            if (push && i == int'(rem)) begin
                hw_d[i]  = fetch_skip_lo ? fetch_data[31:16] : fetch_data[15:0];
                err_d[i] = fetch_err;
            end
            if (push && !fetch_skip_lo && i == int'(rem) + 1) begin
                hw_d[i]  = fetch_data[31:16];
                err_d[i] = fetch_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < DEPTH_HW; i++) begin
                hw_q[i] <= 16'h0;
            end
        end else if (flush) begin
            // Stale halfwords stay in storage; level 0 hides them.
            level_q <= '0;
            err_q   <= '0;
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH_HW; i++) begin
                hw_q[i] <= hw_d[i];
            end
        end
    end

endmodule

// File: tb/tb_hazard3_instr_aligner.sv
// Self-checking bench for hazard3_instr_aligner: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_hazard3_instr_aligner;

    localparam int DEPTH_HW = 6;
    localparam int W_LEVEL  = 3;

    logic               clk = 1'b0;
    logic               rst, flush, fetch_valid, fetch_ready, fetch_skip_lo, fetch_err;
    logic [31:0]        fetch_data, dec_instr;
    logic               dec_valid, dec_ready, dec_is_32bit, dec_err;
    logic [W_LEVEL-1:0] level;

    hazard3_instr_aligner #(
        .DEPTH_HW(DEPTH_HW),
        .W_LEVEL (W_LEVEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_data   (fetch_data),
        .fetch_skip_lo(fetch_skip_lo),
        .fetch_err    (fetch_err),
        .dec_instr    (dec_instr),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_is_32bit (dec_is_32bit),
        .dec_err      (dec_err),
        .level        (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int lv, input logic [31:0] ins,
                            input logic v, input logic i32, input logic e, input logic fr);
        chk({tag, " level"}, 32'(level), 32'(lv));
        chk({tag, " dec_instr"}, dec_instr, ins);
        chk({tag, " dec_valid"}, 32'(dec_valid), 32'(v));
        chk({tag, " dec_is_32bit"}, 32'(dec_is_32bit), 32'(i32));
        chk({tag, " dec_err"}, 32'(dec_err), 32'(e));
        chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'(fr));
    endtask

    task automatic idle();
        rst = 0; flush = 0; fetch_valid = 0; fetch_data = '0;
        fetch_skip_lo = 0; fetch_err = 0; dec_ready = 0;
    endtask

    typedef struct {
        logic        rst, flush, fv;
        logic [31:0] data;
        logic        skip, ferr, rdy;
        int          lvl;
        logic [31:0] instr;
        logic        v, is32, err, fr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, f, fv, input logic [31:0] d, input logic sk, fe, rd,
                       input int lv, input logic [31:0] ins, input logic v, i32, e, fr);
        vec_t t;
        t.rst = r; t.flush = f; t.fv = fv; t.data = d; t.skip = sk; t.ferr = fe; t.rdy = rd;
        t.lvl = lv; t.instr = ins; t.v = v; t.is32 = i32; t.err = e; t.fr = fr;
        vecs.push_back(t);
    endtask

    // Reference model: a plain queue of {err, halfword}.
    logic [16:0] mq[$];

    task automatic model_expect(output int lv, output logic [31:0] ins, output logic v,
                                output logic i32, output logic e, output logic fr);
        logic [15:0] h0;
        lv  = mq.size();
        h0  = (lv >= 1) ? mq[0][15:0] : 16'h0;
        i32 = (lv >= 1) && (h0[1:0] == 2'b11);
        ins = (lv >= 2) ? {mq[1][15:0], mq[0][15:0]} : {16'h0, h0};
        v   = !flush && (lv >= 1) && (!i32 || lv >= 2);
        e   = (lv >= 1) && (mq[0][16] || (i32 && lv >= 2 && mq[1][16]));
        fr  = !flush && (lv <= DEPTH_HW - 2);
    endtask

    initial begin
        int          lv;
        logic [31:0] ins;
        logic        v, i32, e, fr;

        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 idle();
        #1 chk_outs("reset", 0, 32'h0, 0, 0, 0, 1);

        //   rst f fv data          sk fe rd  lvl instr         v i32 e fr
        add(0, 0, 1, 32'h45014505, 0, 0, 0,  2, 32'h45014505, 1, 0, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  1, 32'h00004501, 1, 0, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);
        add(0, 0, 1, 32'h00000013, 0, 0, 1,  2, 32'h00000013, 1, 1, 0, 1);
        add(0, 0, 1, 32'h00A00093, 0, 0, 1,  2, 32'h00A00093, 1, 1, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);
        add(0, 0, 1, 32'h00134501, 0, 0, 0,  2, 32'h00134501, 1, 0, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  1, 32'h00000013, 0, 1, 0, 1);
        add(0, 0, 1, 32'h45050000, 0, 0, 1,  3, 32'h00000013, 1, 1, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  1, 32'h00004505, 1, 0, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);
        add(0, 0, 1, 32'h45014501, 0, 0, 0,  2, 32'h45014501, 1, 0, 0, 1);
        add(0, 0, 1, 32'h45024502, 0, 0, 0,  4, 32'h45014501, 1, 0, 0, 1);
        add(0, 0, 1, 32'h45034503, 0, 0, 0,  6, 32'h45014501, 1, 0, 0, 0);
        add(0, 0, 1, 32'h45044504, 0, 0, 1,  5, 32'h45024501, 1, 0, 0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 1,  4, 32'h45024502, 1, 0, 0, 1);
        add(0, 1, 1, 32'h00000013, 0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);
        add(0, 0, 1, 32'h00000013, 0, 0, 0,  2, 32'h00000013, 1, 1, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);
        add(0, 0, 1, 32'h4505ABCD, 1, 1, 0,  1, 32'h00004505, 1, 0, 1, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);
        add(0, 0, 1, 32'h0013ABCD, 1, 0, 0,  1, 32'h00000013, 0, 1, 0, 1);
        add(0, 0, 1, 32'h55550000, 0, 1, 1,  3, 32'h00000013, 1, 1, 1, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  1, 32'h00005555, 1, 0, 1, 1);
        add(0, 0, 0, 32'h0,        0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);
        add(0, 0, 1, 32'h4505ABCD, 1, 0, 0,  1, 32'h00004505, 1, 0, 0, 1);
        add(0, 0, 1, 32'h22222222, 0, 1, 0,  3, 32'h22224505, 1, 0, 0, 1);
        add(1, 0, 1, 32'h00000013, 0, 0, 1,  0, 32'h00000000, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; flush = vecs[i].flush; fetch_valid = vecs[i].fv;
            fetch_data = vecs[i].data; fetch_skip_lo = vecs[i].skip;
            fetch_err = vecs[i].ferr; dec_ready = vecs[i].rdy;
            @(posedge clk);
            #1 idle();
            #1 chk_outs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].instr, vecs[i].v,
                        vecs[i].is32, vecs[i].err, vecs[i].fr);
        end

        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst           = ($urandom_range(0, 199) == 0);
            flush         = ($urandom_range(0, 31) == 0);
            fetch_valid   = ($urandom_range(0, 2) != 0);
            fetch_data    = $urandom;
            fetch_skip_lo = ($urandom_range(0, 5) == 0);
            fetch_err     = ($urandom_range(0, 9) == 0);
            dec_ready     = ($urandom_range(0, 2) != 0);
            #1;
            model_expect(lv, ins, v, i32, e, fr);
            chk_outs($sformatf("rand%0d", cyc), lv, ins, v, i32, e, fr);
            chk($sformatf("rand%0d level bound", cyc), 32'(int'(level) <= DEPTH_HW), 32'd1);
            @(posedge clk);
            if (rst || flush) begin
                mq.delete();
            end else begin
                if (v && dec_ready) begin
                    void'(mq.pop_front());
                    if (i32) void'(mq.pop_front());
                end
                if (fetch_valid && fr) begin
                    if (!fetch_skip_lo) mq.push_back({fetch_err, fetch_data[15:0]});
                    mq.push_back({fetch_err, fetch_data[31:16]});
                end
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
